// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern driver: OFF / steady ON / continuous BLINK / counted FLASH.
// Latency: a command accepted on edge T shows on leds at T+1; done pulses one cycle at FLASH end.
// No backpressure: every cmd_valid edge is taken and preempts whatever is running.
module led_pattern_ctrl #(
  parameter int N_LED       = 4,
  parameter int HALF_PERIOD = 25000000,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_mode,
  input  logic [N_LED-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [N_LED-1:0] leds,
  output logic             busy,
  output logic             done
);

  // Prescaler just wide enough to count 0..HALF_PERIOD-1.
  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(HALF_PERIOD - 1);

  // Command encodings.
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_FLASH = 2'd3;

  // Controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ON    = 2'd1;
  localparam logic [1:0] ST_BLINK = 2'd2;
  localparam logic [1:0] ST_FLASH = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [N_LED-1:0] mask_q,  mask_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             phase_q, phase_d;
  logic [N_LED-1:0] leds_q,  leds_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic running;
  logic tick;

  // The prescaler only advances while a waveform is being generated.
  always_comb begin
    running = (state_q == ST_BLINK) || (state_q == ST_FLASH);
    tick    = running && (presc_q == PRESC_LAST);
  end

  // Next-state logic: a new command always wins over any in-flight tick or completion.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (cmd_valid) begin
      // Preemption: restart timing from scratch, drop any pending FLASH without done.
      mask_d  = cmd_mask;
      presc_d = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
      phase_d = 1'b0;
      case (cmd_mode)
        MODE_OFF: begin
          state_d = ST_IDLE;
        end
        MODE_ON: begin
          state_d = ST_ON;
        end
        MODE_BLINK: begin
          state_d = ST_BLINK;
          phase_d = 1'b1;
        end
        MODE_FLASH: begin
          if (cmd_count == '0) begin
            // Nothing to flash: report completion straight away.
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FLASH;
            cnt_d   = cmd_count;
            busy_d  = 1'b1;
            phase_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (running) begin
      if (tick) begin
        presc_d = '0;
        phase_d = ~phase_q;
        // A tick during the off-phase closes one on/off pair of a FLASH.
        if ((state_q == ST_FLASH) && !phase_q) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      // IDLE and ON keep the timing state parked at zero.
      presc_d = '0;
      phase_d = 1'b0;
    end
  end

  // LED drive is derived from the next state so it is registered alongside it.
  always_comb begin
    leds_d = '0;
    case (state_d)
      ST_ON:    leds_d = mask_d;
      ST_BLINK: leds_d = phase_d ? mask_d : '0;
      ST_FLASH: leds_d = phase_d ? mask_d : '0;
      default:  leds_d = '0;
    endcase
  end

  // State registers with synchronous active-low reset; reset beats any command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      presc_q <= '0;
      phase_q <= 1'b0;
      leds_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign leds = leds_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with a 4-cycle half period.
// Each step drives inputs at a falling edge and checks outputs at the next falling edge.
// Multi-cycle corner cases (flash count, preemption, completion race) are hand sequences.
module tb_led_pattern_ctrl;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_FLASH = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_mask;
  logic [3:0] cmd_count;
  logic [3:0] leds;
  logic       busy;
  logic       done;

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    logic       v;
    logic [1:0] mode;
    logic [3:0] mask;
    logic [3:0] cnt;
    logic [3:0] e_leds;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  led_pattern_ctrl #(
    .N_LED       (4),
    .HALF_PERIOD (4),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_mode  (cmd_mode),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
    .leds      (leds),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] el, input logic eb, input logic ed);
    tests_run++;
    if (leds !== el || busy !== eb || done !== ed) begin
      fails++;
      $display("FAIL %s: got leds=%b busy=%b done=%b, expected leds=%b busy=%b done=%b",
               nm, leds, busy, done, el, eb, ed);
    end
  endtask

  // Present inputs for one rising edge, then return at the following falling edge.
  task automatic step(input logic v, input logic [1:0] m, input logic [3:0] mk, input logic [3:0] c);
    cmd_valid = v;
    cmd_mode  = m;
    cmd_mask  = mk;
    cmd_count = c;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, M_OFF, 4'h0, 4'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = M_OFF;
    cmd_mask  = 4'h0;
    cmd_count = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 4'h0, 1'b0, 1'b0);

    // Reset in the middle of an ON command, with a command still asserted.
    rst_n = 1'b1;
    step(1'b1, M_ON, 4'hF, 4'h0);
    check("on_before_reset", 4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, M_ON, 4'hF, 4'h0);
    check("reset_overrides_cmd", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check($sformatf("reset_stays_low_%0d", i), 4'h0, 1'b0, 1'b0);
    end

    // Table: BLINK waveform, FLASH count 0, ON hold, held cmd_valid restarts, OFF.
    vecs.push_back('{1'b1, M_BLINK, 4'b0101, 4'h0, 4'b0101, 1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0101, 1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0101, 1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0101, 1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0101, 1'b0, 1'b0});
    vecs.push_back('{1'b1, M_FLASH, 4'hF,    4'h0, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, M_ON,    4'b0011, 4'h7, 4'b0011, 1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'b0011, 1'b0, 1'b0});
    vecs.push_back('{1'b1, M_BLINK, 4'hF,    4'h0, 4'hF,    1'b0, 1'b0});
    vecs.push_back('{1'b1, M_BLINK, 4'hF,    4'h0, 4'hF,    1'b0, 1'b0});
    vecs.push_back('{1'b1, M_BLINK, 4'hF,    4'h0, 4'hF,    1'b0, 1'b0});
    vecs.push_back('{1'b1, M_BLINK, 4'hF,    4'h0, 4'hF,    1'b0, 1'b0});
    vecs.push_back('{1'b1, M_BLINK, 4'hF,    4'h0, 4'hF,    1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'hF,    1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'hF,    1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'hF,    1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'h0,    1'b0, 1'b0});
    vecs.push_back('{1'b1, M_ON,    4'b1010, 4'h0, 4'b1010, 1'b0, 1'b0});
    vecs.push_back('{1'b1, M_OFF,   4'hF,    4'h0, 4'h0,    1'b0, 1'b0});
    vecs.push_back('{1'b0, M_OFF,   4'h0,    4'h0, 4'h0,    1'b0, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].mode, vecs[i].mask, vecs[i].cnt);
      check($sformatf("vec_%0d", i), vecs[i].e_leds, vecs[i].e_busy, vecs[i].e_done);
    end

    // FLASH count 3: three 4-on/4-off pairs, done exactly at T+25.
    step(1'b1, M_FLASH, 4'hF, 4'd3);
    check("flash3_k1", 4'hF, 1'b1, 1'b0);
    for (int k = 2; k <= 27; k++) begin
      idle();
      if (k <= 24)
        check($sformatf("flash3_k%0d", k), ((((k - 1) / 4) % 2) == 0) ? 4'hF : 4'h0, 1'b1, 1'b0);
      else if (k == 25)
        check("flash3_done", 4'h0, 1'b0, 1'b1);
      else
        check($sformatf("flash3_after_k%0d", k), 4'h0, 1'b0, 1'b0);
    end

    // FLASH count 5 preempted during its second on-phase (T+9..T+12).
    step(1'b1, M_FLASH, 4'hF, 4'd5);
    for (int k = 2; k <= 10; k++) idle();
    check("preempt_in_on2", 4'hF, 1'b1, 1'b0);
    step(1'b1, M_ON, 4'b1000, 4'd0);
    check("preempt_on", 4'b1000, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) begin
      idle();
      if (k % 10 == 0 || done !== 1'b0)
        check($sformatf("preempt_hold_%0d", k), 4'b1000, 1'b0, 1'b0);
    end

    // OFF arriving on the very edge that would complete a FLASH count 1.
    step(1'b1, M_FLASH, 4'hF, 4'd1);
    for (int k = 2; k <= 8; k++) idle();
    check("race_last_off_phase", 4'h0, 1'b1, 1'b0);
    step(1'b1, M_OFF, 4'h0, 4'd0);
    check("race_cmd_wins", 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle();
      check($sformatf("race_no_done_%0d", k), 4'h0, 1'b0, 1'b0);
    end

    // Same FLASH count 1 left alone completes at T+9.
    step(1'b1, M_FLASH, 4'b0110, 4'd1);
    for (int k = 2; k <= 8; k++) idle();
    idle();
    check("flash1_done", 4'h0, 1'b0, 1'b1);
    idle();
    check("flash1_done_once", 4'h0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
